// File: rtl/dac_serial_tx_pkg.sv
// rtl/dac_serial_tx_pkg.sv - shared constants and state encoding for the serial DAC transmitter
package dac_serial_tx_pkg;

   localparam int FRAME_BITS   = 16;
   localparam int CMD_BITS     = 4;
   localparam int DEF_DAC_BITS = 12;
   localparam logic [CMD_BITS-1:0] DEF_CMD = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/dac_serial_tx_sat_offset_conv.sv
// rtl/dac_serial_tx_sat_offset_conv.sv - clamp a signed sample to +/-1.0 and convert to offset-binary code
module sat_offset_conv #(
   parameter int Width     = 23,
   parameter int Presicion = 14,
   parameter int DacBits   = 12
) (
   input  logic signed [Width-1:0] sample,
   output logic [DacBits-1:0]      code
);

   localparam int Magnitud = Width - Presicion - 1;
   localparam int SHIFT    = Presicion + 1 - DacBits;

   // Limits built at full sample width so the comparison never wraps.
   localparam logic signed [Width-1:0] POS_LIM = {{(Magnitud + 1){1'b0}}, {Presicion{1'b1}}};
   localparam logic signed [Width-1:0] NEG_LIM = {{(Magnitud + 1){1'b1}}, {Presicion{1'b0}}};

   logic [Presicion:0] clamped;
   logic [Presicion:0] offset;

   // Clamp to [-2^P, 2^P-1]; the in-range value fits in P+1 bits, and adding
   // 2^P modulo 2^(P+1) is just an inversion of its top bit.
   always_comb begin
      if (sample > POS_LIM) begin
         clamped = {1'b0, {Presicion{1'b1}}};
      end else if (sample < NEG_LIM) begin
         clamped = {1'b1, {Presicion{1'b0}}};
      end else begin
         clamped = sample[Presicion:0];
      end
      offset = {~clamped[Presicion], clamped[Presicion-1:0]};
      code   = DacBits'(offset >> SHIFT);
   end

endmodule

// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - serializes saturated filter samples into 16-bit SPI-style DAC frames
module dac_serial_tx
   import dac_serial_tx_pkg::*;
#(
   parameter int Width     = 23,
   parameter int Presicion = 14,
   parameter int DacBits   = DEF_DAC_BITS,
   parameter int ClkDiv    = 4,
   parameter logic [CMD_BITS-1:0] Cmd = DEF_CMD
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [Width-1:0] yk,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun,
   output logic                    sclk,
   output logic                    sync_n,
   output logic                    sdata
);

   localparam int CNT_W = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
   localparam int BIT_W = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(ClkDiv - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

   state_t                  state;
   state_t                  next_state;
   logic [CNT_W-1:0]        half_cnt;
   logic [BIT_W-1:0]        bit_cnt;
   logic [FRAME_BITS-1:0]   shreg;
   logic [DacBits-1:0]      code;
   logic [FRAME_BITS-1:0]   frame;
   logic                    half_end;
   logic                    load;

   sat_offset_conv #(
      .Width     (Width),
      .Presicion (Presicion),
      .DacBits   (DacBits)
   ) u_conv (
      .sample (yk),
      .code   (code)
   );

   assign frame    = {Cmd, code};
   assign half_end = (half_cnt == HALF_LAST);
   assign busy     = (state != ST_IDLE);
   assign overrun  = start & busy;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode, frame load strobe and end-of-frame pulse.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_SHIFT;
               load       = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (half_end && !sclk && (bit_cnt == BIT_LAST)) begin
               next_state = ST_GAP;
            end
         end
         ST_GAP: begin
            if (half_end) begin
               next_state = ST_IDLE;
               done       = 1'b1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Half-period timing, bit sequencing and registered serial outputs; sdata
   // only moves when sclk goes high (or sync_n falls), so it is stable across
   // every falling edge the DAC samples on.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         half_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         sclk     <= 1'b1;
         sync_n   <= 1'b1;
         sdata    <= 1'b0;
      end else if (load) begin
         half_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= {frame[FRAME_BITS-2:0], 1'b0};
         sclk     <= 1'b1;
         sync_n   <= 1'b0;
         sdata    <= frame[FRAME_BITS-1];
      end else if (state == ST_SHIFT) begin
         if (!half_end) begin
            half_cnt <= half_cnt + 1'b1;
         end else begin
            half_cnt <= '0;
            if (sclk) begin
               sclk <= 1'b0;
            end else if (bit_cnt == BIT_LAST) begin
               sclk   <= 1'b1;
               sync_n <= 1'b1;
               sdata  <= 1'b0;
            end else begin
               sclk    <= 1'b1;
               bit_cnt <= bit_cnt + 1'b1;
               sdata   <= shreg[FRAME_BITS-1];
               shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
         end
      end else if (state == ST_GAP) begin
         half_cnt <= half_end ? '0 : half_cnt + 1'b1;
      end
   end

endmodule
